bin2bcd_formatter: RTL and testbench

//   Upstream feeder of the 8-digit seven-segment display driver. Takes a binary ALU result and

---
 rtl/alu_display_pkg.sv | 15 +
 rtl/dabble_adjust.sv | 14 +
 rtl/bin2bcd_formatter.sv | 128 ++++++++++++
 tb/tb_bin2bcd_formatter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_display_pkg.sv
// Shared types and constants for the ALU result display path.
package alu_display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} b2b_state_t;

  localparam int                DISP_DIGITS         = 8;
  localparam logic [3:0]        BCD_MINUS           = 4'hF;
  localparam logic [31:0]       DEFAULT_ERR_PATTERN = 32'hEEEE_EEEE;

  // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2)).
  function automatic int bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/dabble_adjust.sv
// Double-dabble correction: every BCD nibble >= 5 gets +3 ahead of the left shift.
module dabble_adjust #(
  parameter int DIGITS = 10
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [4*DIGITS-1:0] bcd_out
);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign bcd_out[4*g +: 4] = (bcd_in[4*g +: 4] >= 4'd5) ? bcd_in[4*g +: 4] + 4'd3
                                                          : bcd_in[4*g +: 4];
  end

endmodule

// File: rtl/bin2bcd_formatter.sv
// Sequential binary-to-BCD converter feeding the 8-digit display driver, one bit per clock.
// Define SIGNED_EN to treat value as two's complement with a leading minus marker digit.
//
//   state | meaning
//   IDLE  | waiting for start; number/ovf hold the last result
//   CONV  | shifting one input bit per cycle through the BCD accumulator
//   DONE  | result registered, load pulses for this single cycle
module bin2bcd_formatter
  import alu_display_pkg::*;
#(
  parameter int                       IN_W        = 32,
  parameter int                       OUT_DIGITS  = DISP_DIGITS,
  parameter logic [4*OUT_DIGITS-1:0]  ERR_PATTERN = DEFAULT_ERR_PATTERN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IN_W-1:0]          value,
  output logic                     busy,
  output logic                     load,
  output logic [4*OUT_DIGITS-1:0]  number,
  output logic                     ovf
);

  localparam int BCD_DIGITS = bcd_digits(IN_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = (IN_W > 1) ? $clog2(IN_W) : 1;

  b2b_state_t              state;
  logic [CNT_W-1:0]        cnt;
  logic [BCD_W-1:0]        bcd;
  logic [IN_W-1:0]         bin;
  logic [IN_W-1:0]         mag;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W-1:0]        bcd_next;
  logic [4*OUT_DIGITS-1:0] num_fmt;
  logic                    hi_nz;
  int                      ovf_lim;

`ifdef SIGNED_EN
  logic neg;

  // Negating the most negative value wraps to itself, which reads correctly as unsigned.
  assign mag = value[IN_W-1] ? -value : value;
`else
  assign mag = value;
`endif

  dabble_adjust #(.DIGITS(BCD_DIGITS)) u_adjust (
    .bcd_in  (bcd),
    .bcd_out (bcd_adj)
  );

  assign bcd_next = {bcd_adj[BCD_W-2:0], bin[IN_W-1]};

  always_comb begin
    ovf_lim = OUT_DIGITS;
    hi_nz   = 1'b0;
    num_fmt = '0;
`ifdef SIGNED_EN
    if (neg) ovf_lim = OUT_DIGITS - 1;
`endif
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (i >= ovf_lim && bcd_next[4*i +: 4] != 4'h0) hi_nz = 1'b1;
    end
    for (int i = 0; i < OUT_DIGITS; i++) begin
      if (i < BCD_DIGITS) num_fmt[4*i +: 4] = bcd_next[4*i +: 4];
    end
`ifdef SIGNED_EN
    if (neg) num_fmt[4*OUT_DIGITS-1 -: 4] = BCD_MINUS;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      bcd    <= '0;
      bin    <= '0;
      busy   <= 1'b0;
      load   <= 1'b0;
      number <= '0;
      ovf    <= 1'b0;
`ifdef SIGNED_EN
      neg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          load <= 1'b0;
          if (start && !busy) begin
            state <= CONV;
            busy  <= 1'b1;
            cnt   <= CNT_W'(IN_W - 1);
            bcd   <= '0;
            bin   <= mag;
`ifdef SIGNED_EN
            neg   <= value[IN_W-1];
`endif
          end
        end
        CONV: begin
          bcd <= bcd_next;
          bin <= bin << 1;
          if (cnt == '0) begin
            state  <= DONE;
            load   <= 1'b1;
            ovf    <= hi_nz;
            number <= hi_nz ? ERR_PATTERN : num_fmt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          load  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          load  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_formatter.sv
// Directed bench for bin2bcd_formatter: vector table plus back-to-back, ignored-start and reset sequences.
module tb_bin2bcd_formatter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        load;
  logic [31:0] number;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] value;
    logic [31:0] number;
    logic        ovf;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  bin2bcd_formatter dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .value  (value),
    .busy   (busy),
    .load   (load),
    .number (number),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is positioned just after a clock edge with the DUT idle.
  // Returns the number of edges from driving start until load is seen high.
  task automatic do_conv(input logic [31:0] v, output int lat);
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!load && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat;
  int loads;
  int load_lat;
  logic [31:0] load_num;

  initial begin
`ifdef SIGNED_EN
    vecs[0] = '{32'hFFFF_FFD6, 32'hF000_0042, 1'b0};
    vecs[1] = '{32'hFF67_6980, 32'hEEEE_EEEE, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'hEEEE_EEEE, 1'b1};
    vecs[3] = '{32'd42,        32'h0000_0042, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hF000_0001, 1'b0};
    vecs[5] = '{32'hFF67_6981, 32'hF999_9999, 1'b0};
    vecs[6] = '{32'd99999999,  32'h9999_9999, 1'b0};
    vecs[7] = '{32'd100000000, 32'hEEEE_EEEE, 1'b1};
    vecs[8] = '{32'd0,         32'h0000_0000, 1'b0};
`else
    vecs[0] = '{32'd0,         32'h0000_0000, 1'b0};
    vecs[1] = '{32'd12345678,  32'h1234_5678, 1'b0};
    vecs[2] = '{32'd99999999,  32'h9999_9999, 1'b0};
    vecs[3] = '{32'd100000000, 32'hEEEE_EEEE, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hEEEE_EEEE, 1'b1};
    vecs[5] = '{32'd7,         32'h0000_0007, 1'b0};
    vecs[6] = '{32'd10000000,  32'h1000_0000, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'hEEEE_EEEE, 1'b1};
    vecs[8] = '{32'd1,         32'h0000_0001, 1'b0};
`endif

    rst   = 1'b0;
    start = 1'b0;
    value = '0;
    @(posedge clk); #1;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_load",   {31'd0, load}, 32'd0);
    check("reset_ovf",    {31'd0, ovf},  32'd0);
    check("reset_number", number,        32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_conv(vecs[i].value, lat);
      check($sformatf("v%0d_latency", i), lat,               32'd33);
      check($sformatf("v%0d_number", i),  number,            vecs[i].number);
      check($sformatf("v%0d_ovf", i),     {31'd0, ovf},      {31'd0, vecs[i].ovf});
      check($sformatf("v%0d_busy_load", i), {31'd0, busy},   32'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_load_drop", i), {31'd0, load},   32'd0);
      check($sformatf("v%0d_busy_drop", i), {31'd0, busy},   32'd0);
      check($sformatf("v%0d_hold", i),      number,          vecs[i].number);
    end

    // Second start mid-conversion must be ignored; a start in the first idle cycle is taken.
    loads    = 0;
    load_lat = 0;
    load_num = '0;
    start = 1'b1;
    value = 32'd5;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1)  start = 1'b0;
      if (c == 10) begin start = 1'b1; value = 32'd9; end
      if (c == 11) start = 1'b0;
      if (load) begin
        loads++;
        load_lat = c;
        load_num = number;
      end
    end
    check("ignore_single_load", loads,    32'd1);
    check("ignore_latency",     load_lat, 32'd33);
    check("ignore_number",      load_num, 32'h0000_0005);
    check("ignore_idle",        {31'd0, busy}, 32'd0);

    @(posedge clk); #1;
    do_conv(32'd9, lat);
    check("b2b_latency", lat,    32'd33);
    check("b2b_number",  number, 32'h0000_0009);
    @(posedge clk); #1;
    do_conv(32'd12345678, lat);
    check("throughput_latency", lat,    32'd33);
    check("throughput_number",  number, 32'h1234_5678);
    @(posedge clk); #1;

    // Reset during CONV aborts the conversion and clears outputs at once.
    start = 1'b1;
    value = 32'd87654321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_load",   {31'd0, load}, 32'd0);
    check("rst_ovf",    {31'd0, ovf},  32'd0);
    check("rst_number", number,        32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    loads = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (load) loads++;
    end
    check("rst_no_load", loads,  32'd0);
    check("rst_held",    number, 32'd0);
    do_conv(32'd42, lat);
    check("post_rst_latency", lat,    32'd33);
    check("post_rst_number",  number, 32'h0000_0042);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
